// File: rtl/uart_tx_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder_pkg
//  Purpose  : Shared constants and the feeder FSM state encoding for the
//             UART transmit byte queue.
//  Contents : c_AMSB_DEFAULT / c_TMSB_DEFAULT - default FIFO and timeout sizes
//             c_ST_*                         - 2-bit FSM state codes
//             state_e                        - FSM state type
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_feeder_pkg;

    // FIFO address MSB: depth = 2**(AMSB+1) = 16 bytes.
    localparam int unsigned c_AMSB_DEFAULT = 3;
    // Acknowledge-timeout counter MSB: timeout = 2**(TMSB+1) = 256 cycles.
    localparam int unsigned c_TMSB_DEFAULT = 7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_PUSH = 2'd2;
    localparam logic [1:0] c_ST_ACK  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = c_ST_IDLE,
        S_LOAD = c_ST_LOAD,
        S_PUSH = c_ST_PUSH,
        S_ACK  = c_ST_ACK
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock 8-bit FIFO with binary pointers, level count and
//             sticky overflow flag.
//  Ports    : clk, rstn      - clock, asynchronous active-low reset
//             clear_i        - synchronous flush of pointers and ovf
//             wr_i, wdata_i  - write strobe and byte
//             pop_i          - advance the read pointer (ignored when empty)
//             rdata_o        - head byte (valid while !empty_o)
//             full_o/empty_o - occupancy flags
//             level_o        - entry count 0..2**(AMSB+1)
//             ovf_o          - sticky: write attempted while full
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int AMSB = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clear_i,
    input  logic            wr_i,
    input  logic [7:0]      wdata_i,
    input  logic            pop_i,
    output logic [7:0]      rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [AMSB+1:0] level_o,
    output logic            ovf_o
);

    localparam int c_DEPTH = 2 ** (AMSB + 1);

    logic [7:0]      r_mem_q [c_DEPTH];
    logic [AMSB+1:0] r_wptr_q;
    logic [AMSB+1:0] w_wptr_d;
    logic [AMSB+1:0] r_rptr_q;
    logic [AMSB+1:0] w_rptr_d;
    logic            r_ovf_q;
    logic            w_ovf_d;
    logic            w_push;
    logic            w_pop;

    // The extra pointer bit distinguishes full (wrapped once) from empty.
    assign full_o  = (r_wptr_q[AMSB+1] != r_rptr_q[AMSB+1]) &&
                     (r_wptr_q[AMSB:0] == r_rptr_q[AMSB:0]);
    assign empty_o = (r_wptr_q == r_rptr_q);
    assign level_o = r_wptr_q - r_rptr_q;
    assign rdata_o = r_mem_q[r_rptr_q[AMSB:0]];
    assign ovf_o   = r_ovf_q;

    // Full is judged on the registered state, so a pop in the same cycle does
    // not make room for a write that arrives while full.
    assign w_push = wr_i && !full_o && !clear_i;
    assign w_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        w_ovf_d  = r_ovf_q;
        if (clear_i) begin
            w_wptr_d = '0;
            w_rptr_d = '0;
            w_ovf_d  = 1'b0;
        end else begin
            if (w_push) begin
                w_wptr_d = r_wptr_q + 1'b1;
            end
            if (w_pop) begin
                w_rptr_d = r_rptr_q + 1'b1;
            end
            if (wr_i && full_o) begin
                w_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_ovf_q  <= 1'b0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
            r_ovf_q  <= w_ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem_q[i] <= 8'd0;
            end
        end else if (w_push) begin
            r_mem_q[r_wptr_q[AMSB:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Purpose  : Transmit byte queue feeding a UART transmitter through a
//             toggle-push / tx_empty handshake, with level, overflow and
//             acknowledge-timeout reporting.
//  Ports    : clk, rstn         - clock, asynchronous active-low reset
//             clear             - synchronous flush of FIFO, FSM, sticky flags
//             wr, wdata         - byte write strobe and data
//             full, empty, level- FIFO occupancy
//             ovf, tmo          - sticky overflow / handshake timeout
//             busy              - feeder FSM not idle
//             tx_empty          - transmitter ready (asynchronous, synchronised)
//             tx_push, tx_wdata - toggle push and byte to the transmitter
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int AMSB = c_AMSB_DEFAULT,
    parameter int TMSB = c_TMSB_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clear,
    input  logic            wr,
    input  logic [7:0]      wdata,
    output logic            full,
    output logic            empty,
    output logic [AMSB+1:0] level,
    output logic            ovf,
    output logic            tmo,
    output logic            busy,
    input  logic            tx_empty,
    output logic            tx_push,
    output logic [7:0]      tx_wdata
);

    logic [1:0]  r_txe_sync_q;
    logic        w_txe_s;
    state_e      r_state_q;
    state_e      w_state_d;
    logic [TMSB:0] r_tcnt_q;
    logic [TMSB:0] w_tcnt_d;
    logic        r_tmo_q;
    logic        w_tmo_d;
    logic        r_push_q;
    logic        w_push_d;
    logic [7:0]  r_wdata_q;
    logic [7:0]  w_wdata_d;
    logic        w_pop;
    logic [7:0]  w_head;

    sync_fifo #(
        .AMSB (AMSB)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (clear),
        .wr_i    (wr),
        .wdata_i (wdata),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level),
        .ovf_o   (ovf)
    );

    // tx_empty comes from the transmitter's domain; only the second flop
    // output is ever looked at.
    assign w_txe_s = r_txe_sync_q[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_txe_sync_q <= 2'b00;
        end else begin
            r_txe_sync_q <= {r_txe_sync_q[0], tx_empty};
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_tcnt_d  = r_tcnt_q;
        w_tmo_d   = r_tmo_q;
        w_push_d  = r_push_q;
        w_wdata_d = r_wdata_q;
        w_pop     = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (!empty && w_txe_s) begin
                    w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Latch the head byte and pop it in the same cycle; tx_wdata
                // then stays put until the next LOAD.
                w_wdata_d = w_head;
                w_pop     = 1'b1;
                w_state_d = S_PUSH;
            end
            S_PUSH: begin
                w_push_d  = ~r_push_q;
                w_tcnt_d  = '0;
                w_state_d = S_ACK;
            end
            S_ACK: begin
                if (!w_txe_s) begin
                    w_state_d = S_IDLE;
                end else if (r_tcnt_q == '1) begin
                    // No retry: the byte is considered gone.
                    w_tmo_d   = 1'b1;
                    w_state_d = S_IDLE;
                end else begin
                    w_tcnt_d = r_tcnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= S_IDLE;
            r_tcnt_q  <= '0;
            r_tmo_q   <= 1'b0;
            r_push_q  <= 1'b0;
            r_wdata_q <= 8'd0;
        end else if (clear) begin
            // tx_push / tx_wdata deliberately hold so the transmitter never
            // sees a spurious toggle from a flush.
            r_state_q <= S_IDLE;
            r_tcnt_q  <= '0;
            r_tmo_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_tcnt_q  <= w_tcnt_d;
            r_tmo_q   <= w_tmo_d;
            r_push_q  <= w_push_d;
            r_wdata_q <= w_wdata_d;
        end
    end

    assign tmo      = r_tmo_q;
    assign busy     = (r_state_q != S_IDLE);
    assign tx_push  = r_push_q;
    assign tx_wdata = r_wdata_q;

endmodule
`default_nettype wire
